bcd_digit_sequencer: RTL

// - Producer side of the 7-segment digit interface (4-bit digit code + act_D strobe).
// - Converts a binary count (e.g. train position / step counter) to BCD, iteratively by

---
 rtl/dmfb_disp_pkg.sv | 20 ++
 rtl/bcd_digit_sequencer_if.sv | 32 +++
 rtl/bcd_digit_sequencer_step.sv | 30 +++
 rtl/bcd_digit_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dmfb_disp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmfb_disp_pkg : shared digit-display types (digit code, blank code, FSM states)
// Rev 1.0
// ----------------------------------------------------------------------------
package dmfb_disp_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_digit_sequencer_if : request side plus 7-segment digit strobe interface
// Rev 1.0
// ----------------------------------------------------------------------------
interface bcd_digit_sequencer_if #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 4
);
  import dmfb_disp_pkg::*;

  logic                  start;
  logic [BIN_W-1:0]      value;
  logic                  busy;
  logic                  act_D;
  digit_t                addr;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, value,
    input  busy, act_D, addr, digit_sel, done, ovf
  );

  modport slave (
    input  start, value,
    output busy, act_D, addr, digit_sel, done, ovf
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_sequencer_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_dabble_step : one double-dabble iteration (add-3 correction, then 1-bit shift)
// Rev 1.0
// ----------------------------------------------------------------------------
module bcd_dabble_step #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 4
) (
  input  wire logic [4*NUM_DIGITS-1:0] bcd_i,
  input  wire logic [BIN_W-1:0]        shreg_i,
  output logic      [4*NUM_DIGITS-1:0] bcd_o,
  output logic      [BIN_W-1:0]        shreg_o,
  output logic                         carry_o
);

  logic [4*NUM_DIGITS-1:0] w_corr;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_corr[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? (bcd_i[4*g +: 4] + 4'd3)
                                                         : bcd_i[4*g +: 4];
  end

  // The bit leaving the top digit is worth 10**NUM_DIGITS: it marks overflow.
  assign carry_o = w_corr[4*NUM_DIGITS-1];
  assign bcd_o   = {w_corr[4*NUM_DIGITS-2:0], shreg_i[BIN_W-1]};
  assign shreg_o = shreg_i << 1;

endmodule
`default_nettype wire

// File: rtl/bcd_digit_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_digit_sequencer : binary -> BCD by double dabble, digits streamed MS first
// Rev 1.0
// ----------------------------------------------------------------------------
module bcd_digit_sequencer #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_LZ   = 1
) (
  input wire logic              clock,
  input wire logic              resetn,
  bcd_digit_sequencer_if.slave  bus
);
  import dmfb_disp_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [BCD_W-1:0]      bcd_q,   bcd_d;
  logic [BIN_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  ovf_q,   ovf_d;
  logic                  busy_q,  busy_d;
  logic                  act_q,   act_d;
  logic                  done_q,  done_d;
  digit_t                addr_q,  addr_d;
  logic [NUM_DIGITS-1:0] sel_q,   sel_d;

  logic [BCD_W-1:0]      w_step_bcd;
  logic [BIN_W-1:0]      w_step_shreg;
  logic                  w_step_carry;
  logic                  w_lead_zero;

  bcd_dabble_step #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_step (
    .bcd_i   (bcd_q),
    .shreg_i (shreg_q),
    .bcd_o   (w_step_bcd),
    .shreg_o (w_step_shreg),
    .carry_o (w_step_carry)
  );

  always_comb begin : p_next_state
    state_d = state_q;
    bcd_d   = bcd_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONVERT;
          bcd_d   = '0;
          shreg_d = bus.value;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CONVERT: begin
        bcd_d   = w_step_bcd;
        shreg_d = w_step_shreg;
        ovf_d   = ovf_q | w_step_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = EMIT;
          idx_d   = IDX_TOP;
        end
      end
      EMIT: begin
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered
  // alongside the state; the first digit therefore sees the final dabble step.
  always_comb begin : p_outputs
    busy_d      = (state_d != IDLE);
    act_d       = (state_d == EMIT);
    done_d      = (state_d == DONE);
    sel_d       = '0;
    addr_d      = addr_q;
    w_lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_d) && bcd_d[4*i +: 4] != 4'd0) w_lead_zero = 1'b0;
    end
    if (state_d == EMIT) begin
      sel_d  = NUM_DIGITS'(1) << idx_d;
      addr_d = bcd_d[4*idx_d +: 4];
      if (BLANK_LZ != 0 && idx_d != '0 && w_lead_zero) addr_d = DIGIT_BLANK;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= DIGIT_BLANK;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      act_q   <= act_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.act_D     = act_q;
  assign bus.addr      = addr_q;
  assign bus.digit_sel = sel_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire
